// File: rtl/linterp_sched_if.sv
// linterp_sched_if: valid/ready sample stream from the IFFT into the burst scheduler
interface linterp_sched_if #(
    parameter int DWIDTH = 16
);
    logic              s_valid;
    logic              s_ready;
    logic              s_last;
    logic [DWIDTH-1:0] s_real;
    logic [DWIDTH-1:0] s_imag;

    modport master (output s_valid, s_last, s_real, s_imag, input s_ready);
    modport slave  (input s_valid, s_last, s_real, s_imag, output s_ready);
endinterface

// File: rtl/linterp_sched.sv
// linterp_sched: triple-bank burst scheduler feeding prev/curr sample pairs to a linear interpolator
// Optional LINTERP_SCHED_HOLD_EN: while starved, replay the last burst flat instead of suppressing output.
module linterp_sched #(
    parameter int DWIDTH = 16,
    parameter int INTERP = 32,
    parameter int IWIDTH = $clog2(INTERP),
    parameter int NFFT   = 64,
    parameter int AWIDTH = $clog2(NFFT)
) (
    input  logic              clk,
    input  logic              reset,
    linterp_sched_if.slave    s,
    input  logic              out_stb,
    output logic              dv_out,
    output logic [IWIDTH-1:0] index_out,
    output logic [AWIDTH-1:0] pos_out,
    output logic [DWIDTH-1:0] prev_real,
    output logic [DWIDTH-1:0] prev_imag,
    output logic [DWIDTH-1:0] curr_real,
    output logic [DWIDTH-1:0] curr_imag,
    output logic              underflow,
    output logic [15:0]       underflow_cnt,
    output logic              framing_err
);
`ifdef LINTERP_SCHED_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif
    localparam logic [AWIDTH-1:0] K_LAST = AWIDTH'(NFFT - 1);
    localparam logic [IWIDTH-1:0] P_LAST = IWIDTH'(INTERP - 1);

    typedef enum logic [1:0] {IDLE, RUN, STARVED} state_t;

    logic [2*DWIDTH-1:0] mem [3][NFFT];

    state_t              state_q, state_d;
    logic [1:0]          prv_ptr_q, prv_ptr_d, cur_ptr_q, cur_ptr_d, fil_ptr_q, fil_ptr_d;
    logic                fill_full_q, fill_full_d;
    logic [AWIDTH-1:0]   wr_addr_q, wr_addr_d;
    logic [IWIDTH-1:0]   p_q, p_d;
    logic [AWIDTH-1:0]   k_q, k_d;
    logic                end_q, end_d;
    logic                prev_zero_q, prev_zero_d;
    logic                dv_q, dv_d;
    logic [IWIDTH-1:0]   idx_q, idx_d;
    logic [AWIDTH-1:0]   pos_q, pos_d;
    logic [2*DWIDTH-1:0] prev_dat_q, prev_dat_d, curr_dat_q, curr_dat_d;
    logic                uf_q, uf_d;
    logic [15:0]         ucnt_q, ucnt_d;
    logic                ferr_q, ferr_d;

    logic                wr, wr_last, svc, bnd, rot, starve, adv;
    logic [IWIDTH-1:0]   base_p;
    logic [AWIDTH-1:0]   base_k;
    logic [1:0]          rd_prev, rd_curr;
    logic [2*DWIDTH-1:0] prev_word, curr_word;

    assign s.s_ready     = !fill_full_q && !reset;
    assign wr            = s.s_valid && s.s_ready;
    assign wr_last       = wr_addr_q == K_LAST;

    assign dv_out        = dv_q;
    assign index_out     = idx_q;
    assign pos_out       = pos_q;
    assign prev_real     = prev_dat_q[2*DWIDTH-1:DWIDTH];
    assign prev_imag     = prev_dat_q[DWIDTH-1:0];
    assign curr_real     = curr_dat_q[2*DWIDTH-1:DWIDTH];
    assign curr_imag     = curr_dat_q[DWIDTH-1:0];
    assign underflow     = uf_q;
    assign underflow_cnt = ucnt_q;
    assign framing_err   = ferr_q;

    // Fill bank write port; written samples are never cleared, bank validity lives in the pointers/flags
    always_ff @(posedge clk) begin
        if (wr) mem[fil_ptr_q][wr_addr_q] <= {s.s_real, s.s_imag};
    end

    // Next-state: rotation decision, replay pointer advance, output pair selection, input bookkeeping
    always_comb begin
        state_d     = state_q;
        prv_ptr_d   = prv_ptr_q;
        cur_ptr_d   = cur_ptr_q;
        fil_ptr_d   = fil_ptr_q;
        fill_full_d = fill_full_q;
        wr_addr_d   = wr_addr_q;
        p_d         = p_q;
        k_d         = k_q;
        end_d       = end_q;
        prev_zero_d = prev_zero_q;
        dv_d        = 1'b0;
        idx_d       = idx_q;
        pos_d       = pos_q;
        prev_dat_d  = prev_dat_q;
        curr_dat_d  = curr_dat_q;
        uf_d        = 1'b0;
        ucnt_d      = ucnt_q;
        ferr_d      = ferr_q;
        svc         = out_stb && state_q != IDLE;
        bnd         = state_q == STARVED || end_q;
        rot         = fill_full_q && (state_q == IDLE || (svc && bnd));
        starve      = svc && bnd && !fill_full_q;
        adv         = (svc && !bnd) || (svc && rot) || (starve && HOLD);
        base_p      = rot ? '0 : p_q;
        base_k      = rot ? '0 : k_q;
        rd_prev     = rot ? cur_ptr_q : prv_ptr_q;
        rd_curr     = rot ? fil_ptr_q : cur_ptr_q;
        prev_word   = mem[rd_prev][base_k];
        curr_word   = mem[rd_curr][base_k];
        if (rot) begin
            prv_ptr_d   = cur_ptr_q;
            cur_ptr_d   = fil_ptr_q;
            fil_ptr_d   = prv_ptr_q;
            fill_full_d = 1'b0;
            state_d     = RUN;
            p_d         = '0;
            k_d         = '0;
            end_d       = 1'b0;
            prev_zero_d = svc ? 1'b0 : prev_zero_q;
        end
        if (starve) begin
            state_d = STARVED;
            uf_d    = 1'b1;
            ucnt_d  = (ucnt_q == 16'hFFFF) ? ucnt_q : ucnt_q + 16'd1;
        end
        if (adv) begin
            dv_d       = 1'b1;
            idx_d      = base_p;
            pos_d      = base_k;
            curr_dat_d = curr_word;
            prev_dat_d = starve ? curr_word : ((prev_zero_q && !rot) ? '0 : prev_word);
            k_d        = base_k + 1'b1;
            p_d        = (base_k == K_LAST) ? base_p + 1'b1 : base_p;
            end_d      = starve ? end_q : (base_k == K_LAST && base_p == P_LAST);
        end
        if (wr) begin
            wr_addr_d = wr_addr_q + 1'b1;
            if (wr_last) fill_full_d = 1'b1;
            if (s.s_last != wr_last) ferr_d = 1'b1;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            prv_ptr_q   <= 2'd0;
            cur_ptr_q   <= 2'd1;
            fil_ptr_q   <= 2'd2;
            fill_full_q <= 1'b0;
            wr_addr_q   <= '0;
            p_q         <= '0;
            k_q         <= '0;
            end_q       <= 1'b0;
            prev_zero_q <= 1'b1;
            dv_q        <= 1'b0;
            idx_q       <= '0;
            pos_q       <= '0;
            prev_dat_q  <= '0;
            curr_dat_q  <= '0;
            uf_q        <= 1'b0;
            ucnt_q      <= '0;
            ferr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            prv_ptr_q   <= prv_ptr_d;
            cur_ptr_q   <= cur_ptr_d;
            fil_ptr_q   <= fil_ptr_d;
            fill_full_q <= fill_full_d;
            wr_addr_q   <= wr_addr_d;
            p_q         <= p_d;
            k_q         <= k_d;
            end_q       <= end_d;
            prev_zero_q <= prev_zero_d;
            dv_q        <= dv_d;
            idx_q       <= idx_d;
            pos_q       <= pos_d;
            prev_dat_q  <= prev_dat_d;
            curr_dat_q  <= curr_dat_d;
            uf_q        <= uf_d;
            ucnt_q      <= ucnt_d;
            ferr_q      <= ferr_d;
        end
    end
endmodule

// File: tb/tb_linterp_sched.sv
// tb_linterp_sched: randomized scoreboard bench for linterp_sched with a burst-level reference model
module tb_linterp_sched;
    localparam int DW  = 16;
    localparam int NF  = 4;
    localparam int IN  = 4;
    localparam int TOT = NF * IN;

    typedef logic [NF-1:0][DW-1:0] vec_t;
    typedef struct { vec_t r; vec_t i; } burst_t;
    typedef struct { bit dv; bit uf; int p; int k; logic [DW-1:0] pr, pi, cr, ci; } exp_t;

    logic          clk = 0;
    logic          reset = 1;
    logic          out_stb = 0;
    logic          dv_out, underflow, framing_err;
    logic [1:0]    index_out, pos_out;
    logic [DW-1:0] prev_real, prev_imag, curr_real, curr_imag;
    logic [15:0]   underflow_cnt;

    int errors = 0;
    int checks = 0;

    linterp_sched_if #(.DWIDTH(DW)) ifv ();

    linterp_sched #(.DWIDTH(DW), .INTERP(IN), .NFFT(NF)) dut (
        .clk(clk), .reset(reset), .s(ifv), .out_stb(out_stb),
        .dv_out(dv_out), .index_out(index_out), .pos_out(pos_out),
        .prev_real(prev_real), .prev_imag(prev_imag),
        .curr_real(curr_real), .curr_imag(curr_imag),
        .underflow(underflow), .underflow_cnt(underflow_cnt), .framing_err(framing_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- reference model (burst level) ----------------
    burst_t      avail[$];
    exp_t        sb[$];
    burst_t      cur, prv;
    vec_t        fr, fi;
    bit          pz = 1;
    int          mode = 0;
    int          n = 0;
    int          wb = 0;
    logic [15:0] m_ucnt = 0;
    logic        m_ferr = 0;

    function automatic exp_t mk(int idx, bit flat);
        exp_t e;
        int   k = idx % NF;
        e = '{default: 0};
        e.dv = 1;
        e.k  = k;
        e.p  = (idx / NF) % IN;
        e.cr = cur.r[k];
        e.ci = cur.i[k];
        e.pr = flat ? cur.r[k] : (pz ? '0 : prv.r[k]);
        e.pi = flat ? cur.i[k] : (pz ? '0 : prv.i[k]);
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        chk("s_ready", ifv.s_ready, !reset && avail.size() == 0);
        if (reset) begin
            avail.delete();
            pz = 1; mode = 0; n = 0; wb = 0; m_ucnt = 0; m_ferr = 0;
        end else begin
            if (mode == 0) begin
                if (avail.size() != 0) begin
                    cur = avail.pop_front(); pz = 1; mode = 1; n = 0;
                end
            end else if (out_stb) begin
                if (mode == 1 && n < TOT) begin
                    e = mk(n, 0); n++;
                end else if (avail.size() != 0) begin
                    prv = cur; cur = avail.pop_front(); pz = 0; mode = 1;
                    e = mk(0, 0); n = 1;
                end else begin
                    mode = 2;
                    e = '{default: 0};
`ifdef LINTERP_SCHED_HOLD_EN
                    e = mk(n, 1); n++;
`endif
                    e.uf = 1;
                    if (m_ucnt != 16'hFFFF) m_ucnt++;
                end
                sb.push_back(e);
            end
            if (ifv.s_valid && ifv.s_ready) begin
                fr[wb] = ifv.s_real;
                fi[wb] = ifv.s_imag;
                if (ifv.s_last != (wb == NF - 1)) m_ferr = 1;
                if (wb == NF - 1) begin
                    avail.push_back('{fr, fi});
                    wb = 0;
                end else wb++;
            end
        end
    end

    // ---------------- monitor ----------------
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (dv_out || underflow) begin
            if (sb.size() == 0) chk("unexpected_output", {30'd0, dv_out, underflow}, 0);
            else begin
                e = sb.pop_front();
                chk("dv_out", dv_out, e.dv);
                chk("underflow", underflow, e.uf);
                if (e.dv) begin
                    chk("index_out", index_out, e.p);
                    chk("pos_out", pos_out, e.k);
                    chk("prev_real", prev_real, e.pr);
                    chk("prev_imag", prev_imag, e.pi);
                    chk("curr_real", curr_real, e.cr);
                    chk("curr_imag", curr_imag, e.ci);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle(input int c);
        repeat (c) @(posedge clk);
        #1;
    endtask

    function automatic vec_t rv();
        vec_t v;
        for (int k = 0; k < NF; k++) v[k] = DW'($urandom);
        return v;
    endfunction

    task automatic push_burst(input vec_t r, input vec_t i, input int last_at);
        for (int b = 0; b < NF; b++) begin
            int w = 0;
            ifv.s_valid = 1;
            ifv.s_real  = r[b];
            ifv.s_imag  = i[b];
            ifv.s_last  = (b == last_at);
            @(negedge clk);
            while (!ifv.s_ready && w < 3000) begin
                w++;
                @(negedge clk);
            end
            if (w == 3000) begin
                chk("push_timeout", ifv.s_ready, 1);
                @(posedge clk); #1;
                ifv.s_valid = 0; ifv.s_last = 0;
                return;
            end
            @(posedge clk); #1;
        end
        ifv.s_valid = 0;
        ifv.s_last  = 0;
    endtask

    task automatic strobe_n(input int cnt, input bit gaps);
        for (int j = 0; j < cnt; j++) begin
            out_stb = 1;
            @(posedge clk); #1;
            out_stb = 0;
            if (gaps && $urandom_range(0, 2) == 0) idle(1);
        end
    endtask

    task automatic phase_check(input string nm);
        idle(4);
        chk({nm, "_sb_empty"}, sb.size(), 0);
        sb.delete();
        chk({nm, "_underflow_cnt"}, underflow_cnt, m_ucnt);
        chk({nm, "_framing_err"}, framing_err, m_ferr);
    endtask

    task automatic do_reset();
        reset = 1;
        idle(2);
        reset = 0;
    endtask

    vec_t a_r, a_i;

    initial begin
        ifv.s_valid = 0; ifv.s_last = 0; ifv.s_real = 0; ifv.s_imag = 0;
        a_r = {16'd4, 16'd3, 16'd2, 16'd1};
        a_i = rv();
        idle(3);
        reset = 0;
        chk("rst_dv_out", dv_out, 0);
        chk("rst_index_pos", {index_out, pos_out}, 0);
        chk("rst_prev", {prev_real, prev_imag}, 0);
        chk("rst_curr", {curr_real, curr_imag}, 0);
        chk("rst_underflow", underflow, 0);
        chk("rst_underflow_cnt", underflow_cnt, 0);
        chk("rst_framing_err", framing_err, 0);

        // single burst replayed INTERP times against zero prev
        push_burst(a_r, a_i, NF - 1);
        idle(2);
        strobe_n(TOT, 0);
        phase_check("single");

        // three bursts: rotation, prev=A/curr=B, C accepted after rotation
        do_reset();
        push_burst(a_r, a_i, NF - 1);
        fork
            begin push_burst(rv(), rv(), NF - 1); push_burst(rv(), rv(), NF - 1); end
            begin idle(3); strobe_n(2 * TOT, 1); end
        join
        phase_check("three");

        // starvation then recovery
        do_reset();
        push_burst(a_r, a_i, NF - 1);
        idle(2);
        strobe_n(TOT + 4, 0);
        phase_check("starve");
        chk("starve_cnt4", underflow_cnt, 4);
        push_burst(rv(), rv(), NF - 1);
        idle(2);
        strobe_n(1, 0);
        phase_check("recover");

        // misplaced s_last
        do_reset();
        push_burst(rv(), rv(), 1);
        idle(2);
        chk("framing_set", framing_err, 1);
        push_burst(rv(), rv(), NF - 1);
        strobe_n(TOT + 2, 1);
        phase_check("framing");
        chk("framing_sticky", framing_err, 1);

        // reset in mid-replay at p=2
        do_reset();
        push_burst(rv(), rv(), NF - 1);
        idle(2);
        strobe_n(2 * NF + 1, 0);
        reset = 1; out_stb = 1;
        idle(1);
        reset = 0; out_stb = 0;
        chk("midrst_dv_out", dv_out, 0);
        chk("midrst_underflow_cnt", underflow_cnt, 0);
        strobe_n(5, 1);
        phase_check("midrst_ignore");
        push_burst(rv(), rv(), NF - 1);
        idle(2);
        strobe_n(NF, 0);
        phase_check("midrst_new");

        // random soak with concurrent input and strobes
        do_reset();
        fork
            begin
                for (int b = 0; b < 6; b++) begin
                    push_burst(rv(), rv(), NF - 1);
                    idle($urandom_range(0, 20));
                end
            end
            strobe_n(150, 1);
        join
        phase_check("soak");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
